uctl_fifo_rd_unpack: RTL and testbench
======================================

# uctl_fifo_rd_unpack

FIFO-read unpacker on the transmit path, directly downstream of the USB controller's data FIFO (sync or async wrapper, read side). On a `start` command it pulls FIFO_DATASIZE-bit words from the FIFO read port. It emits exactly `xferLen` bytes, least-significant byte first, to the packet transmitter over a valid/ready byte stream, flags the last byte, and pulses `done` at the end. It runs on the FIFO read clock.

## Interface
Parameters:
- FIFO_DATASIZE, 32, FIFO word width; must be a multiple of 8 (BYTES = FIFO_DATASIZE/8).
- CNT_WIDTH, 11, width of the byte count (max transfer 2^CNT_WIDTH-1 bytes).

Ports:
- clk  in  1  single clock (FIFO read clock).
- rst_n  in  1  synchronous, active-low reset.
- sw_rst  in  1  synchronous, active-high soft reset; same effect as rst_n.
- start  in  1  one-cycle command; ignored unless state is IDLE.
- xferLen  in  CNT_WIDTH  byte count, sampled with start; 0 means zero-length packet.
- fifo_rdEn  out  1  FIFO read strobe.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dataOut  in  FIFO_DATASIZE  FIFO read data; valid the cycle after fifo_rdEn.
- byteOut  out  8  current byte.
- byteValid  out  1  byteOut is valid.
- byteReady  in  1  sink accepts byte.
- byteLast  out  1  current byte is the final byte of the transfer.
- bytesLeft  out  CNT_WIDTH  bytes not yet accepted.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- State machine: IDLE, FETCH, LOAD, SEND, DONE.
- Registers: word register (FIFO_DATASIZE), byte index (log2 BYTES bits, min 1), bytesLeft.
- IDLE:
  - start with xferLen>0: bytesLeft<=xferLen, go to FETCH.
  - start with xferLen==0: go to DONE.
- FETCH: fifo_rdEn = !fifo_empty. If not empty, go to LOAD; otherwise stay in FETCH.
- LOAD: word register <= fifo_dataOut, index <= 0, go to SEND.
- SEND:
  - byteValid=1; byteOut = word[8*idx+7 : 8*idx].
  - byteLast = (bytesLeft==1).
  - On byteValid && byteReady (accept): bytesLeft decrements by 1.
    - If bytesLeft==1: go to DONE.
    - Else if idx==BYTES-1: if !fifo_empty, assert fifo_rdEn in the same cycle and go to LOAD (prefetch); otherwise go to FETCH.
    - Else: idx increments.
- DONE: done=1 for one cycle, then IDLE.
- Partial final word: unsent upper bytes are discarded. Every word read is consumed exactly once.
- fifo_rdEn is never asserted when fifo_empty=1, nor outside FETCH/SEND.
- Hold rule: while byteValid=1 and byteReady=0, byteOut, byteLast and bytesLeft stay stable.
- busy=1 in FETCH, LOAD and SEND; busy=0 in IDLE and DONE.
- start while busy or in DONE: ignored, with no effect on bytesLeft.
- rst_n=0 or sw_rst=1 at any time, including mid-transfer:
  - Next state is IDLE; word register, index and bytesLeft are cleared.
  - No done pulse. Any word already read is lost; the FIFO is not rewound.

## Timing
- Reset values: fifo_rdEn=0, byteOut=0, byteValid=0, byteLast=0, bytesLeft=0, busy=0, done=0.
- Cycle numbering: start is high in cycle 0 and the FIFO is non-empty.
  - Cycle 1: FETCH, fifo_rdEn=1.
  - Cycle 2: LOAD.
  - Cycle 3: first byteValid.
- Throughput with byteReady=1 and a non-empty FIFO: BYTES bytes, then one LOAD gap cycle, repeating.
- DONE follows the cycle of the last accept; done is high for exactly one cycle.
- xferLen=0: done=1 in cycle 1; no fifo_rdEn, no byteValid.
- fifo_rdEn and byteValid are combinational from state, fifo_empty and byteReady. No other comb path exists from inputs to outputs.
- bytesLeft is registered and updates on the edge after an accept.

## Test plan
- Normal 8-byte transfer: FIFO holds 0x44332211 then 0x88776655; xferLen=8; byteReady=1.
  - Bytes 11,22,33,44 in cycles 3-6; bytes 55,66,77,88 in cycles 8-11.
  - byteLast only on 0x88; exactly 2 fifo_rdEn pulses (cycles 1 and 6); done in cycle 12.
- Partial final word: xferLen=5 with the same data.
  - Bytes 11,22,33,44,55 emitted; byteLast on 0x55; 2 reads; FIFO left empty; done one cycle after the 0x55 accept.
- Zero-length packet: xferLen=0 → done in cycle 1, busy stays 0, no fifo_rdEn, no byteValid.
- Stall and backpressure: FIFO empty for 5 cycles after start, and byteReady toggles 1,0,0,1.
  - fifo_rdEn stays 0 while empty.
  - byteOut and bytesLeft are stable while byteReady=0; no byte is lost or duplicated.
- Abort: sw_rst=1 for one cycle while byte 2 of a 12-byte transfer is presented.
  - Next cycle: all outputs at reset values, no done pulse.
  - A following start with xferLen=4 completes normally.
- Start while busy: a second start with xferLen=9 in the middle of an 8-byte transfer is ignored; exactly 8 bytes are emitted and one done pulse occurs.

Source files
------------

// File: rtl/uctl_fifo_rd_unpack_if.sv
// uctl_fifo_rd_unpack_if: FIFO read port plus
// the outgoing byte stream of the unpacker.
interface uctl_fifo_rd_unpack_if #(
  parameter int FIFO_DATASIZE = 32
);
  logic                     fifo_rdEn;
  logic                     fifo_empty;
  logic [FIFO_DATASIZE-1:0] fifo_dataOut;
  logic [7:0]               byteOut;
  logic                     byteValid;
  logic                     byteReady;
  logic                     byteLast;

  modport master (
    output fifo_rdEn,
    input  fifo_empty,
    input  fifo_dataOut,
    output byteOut,
    output byteValid,
    output byteLast,
    input  byteReady
  );

  modport slave (
    input  fifo_rdEn,
    output fifo_empty,
    output fifo_dataOut,
    input  byteOut,
    input  byteValid,
    input  byteLast,
    output byteReady
  );
endinterface

// File: rtl/uctl_fifo_rd_unpack.sv
// uctl_fifo_rd_unpack: pulls FIFO words and emits
// xferLen bytes LSB first on a valid/ready stream.
module uctl_fifo_rd_unpack #(
  parameter int FIFO_DATASIZE = 32,
  parameter int CNT_WIDTH     = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sw_rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] xferLen,
  uctl_fifo_rd_unpack_if.master bus,
  output logic [CNT_WIDTH-1:0] bytesLeft,
  output logic                 busy,
  output logic                 done
);

  localparam int BYTES = FIFO_DATASIZE / 8;
  localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [FIFO_DATASIZE-1:0] word_q, word_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic [CNT_WIDTH-1:0]     left_q, left_d;
  logic                     rd_en;
  logic                     valid;
  logic                     kill;

  assign kill = !rst_n || sw_rst;

  // State and datapath registers; either reset clears everything.
  always_ff @(posedge clk) begin
    if (kill) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
    end
  end

  // Next state, FIFO read strobe and byte handshake.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    left_d  = left_q;
    rd_en   = 1'b0;
    valid   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (xferLen != '0) begin
            left_d  = xferLen;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        rd_en = !bus.fifo_empty;
        if (!bus.fifo_empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        word_d  = bus.fifo_dataOut;
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        valid = 1'b1;
        if (bus.byteReady) begin
          left_d = left_q - CNT_WIDTH'(1);
          if (left_q == CNT_WIDTH'(1)) begin
            state_d = S_DONE;
          end else if (idx_q == LAST_IDX) begin
            // Prefetch the next word while the last byte leaves.
            if (!bus.fifo_empty) begin
              rd_en   = 1'b1;
              state_d = S_LOAD;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.fifo_rdEn = rd_en;
  assign bus.byteValid = valid;
  assign bus.byteOut   = (state_q == S_SEND) ?
                         word_q[{idx_q, 3'b000} +: 8] : 8'h00;
  assign bus.byteLast  = (state_q == S_SEND) &&
                         (left_q == CNT_WIDTH'(1));
  assign bytesLeft     = left_q;
  assign busy          = (state_q == S_FETCH) ||
                         (state_q == S_LOAD)  ||
                         (state_q == S_SEND);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_uctl_fifo_rd_unpack.sv
// tb_uctl_fifo_rd_unpack: directed scenarios with
// hand-computed byte streams and cycle positions.
module tb_uctl_fifo_rd_unpack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sw_rst = 1'b0;
  logic        start = 1'b0;
  logic [10:0] xferLen = '0;
  logic [10:0] bytesLeft;
  logic        busy;
  logic        done;

  int checks = 0;
  int passes = 0;

  uctl_fifo_rd_unpack_if #(.FIFO_DATASIZE(32)) bif();

  uctl_fifo_rd_unpack #(
    .FIFO_DATASIZE(32),
    .CNT_WIDTH(11)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_rst(sw_rst),
    .start(start),
    .xferLen(xferLen),
    .bus(bif),
    .bytesLeft(bytesLeft),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after a read strobe.
  logic [31:0] fmem [16];
  int          fwr = 0;
  int          frd = 0;
  logic        hold_empty = 1'b0;

  assign bif.fifo_empty = (fwr == frd) || hold_empty;

  always @(posedge clk) begin
    if (bif.fifo_rdEn && fwr != frd) begin
      bif.fifo_dataOut <= fmem[frd % 16];
      frd <= frd + 1;
    end
  end

  initial bif.byteReady = 1'b0;

  task automatic push(input logic [31:0] w);
    fmem[fwr % 16] = w;
    fwr = fwr + 1;
  endtask

  // Per-run records.
  logic [7:0]  acc_b [$];
  int          acc_c [$];
  logic        acc_l [$];
  logic [10:0] acc_left [$];
  int          rd_c [$];
  int          done_c [$];
  int          busy_n, valid_n, rd_empty_n, hold_bad;
  logic [7:0]  s_out [32];
  logic [10:0] s_left [32];
  logic        s_val [32];
  logic        s_rdy [32];
  logic        s_last [32];
  logic        s_busy [32];
  logic        s_done [32];
  logic        s_rd [32];

  task automatic run(input int len, input int ncyc,
                     input int empty_until,
                     input logic [3:0] rpat,
                     input int st2_cyc, input int st2_len,
                     input int srst_cyc);
    acc_b.delete();
    acc_c.delete();
    acc_l.delete();
    acc_left.delete();
    rd_c.delete();
    done_c.delete();
    busy_n = 0;
    valid_n = 0;
    rd_empty_n = 0;
    hold_bad = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      start = (c == 0) || (c == st2_cyc);
      xferLen = (c == 0) ? 11'(len) : 11'(st2_len);
      sw_rst = (c == srst_cyc);
      hold_empty = (c < empty_until);
      bif.byteReady = rpat[c % 4];
      #1;
      s_out[c]  = bif.byteOut;
      s_left[c] = bytesLeft;
      s_val[c]  = bif.byteValid;
      s_rdy[c]  = bif.byteReady;
      s_last[c] = bif.byteLast;
      s_busy[c] = busy;
      s_done[c] = done;
      s_rd[c]   = bif.fifo_rdEn;
      if (bif.byteValid && bif.byteReady && !sw_rst) begin
        acc_b.push_back(bif.byteOut);
        acc_c.push_back(c);
        acc_l.push_back(bif.byteLast);
        acc_left.push_back(bytesLeft);
      end
      if (bif.fifo_rdEn) rd_c.push_back(c);
      if (bif.fifo_rdEn && bif.fifo_empty) rd_empty_n++;
      if (done) done_c.push_back(c);
      if (busy) busy_n++;
      if (bif.byteValid) valid_n++;
      if (c > 0 && s_val[c-1] && !s_rdy[c-1]) begin
        if (!s_val[c] || s_out[c] !== s_out[c-1] ||
            s_last[c] !== s_last[c-1] ||
            s_left[c] !== s_left[c-1])
          hold_bad++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    sw_rst = 1'b0;
    hold_empty = 1'b0;
    bif.byteReady = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bif.fifo_rdEn !== 1'b0) $display("FAIL reset_rdEn: got %0b want 0", bif.fifo_rdEn);
    else passes++;
    checks++;
    if (bif.byteOut !== 8'h00) $display("FAIL reset_byteOut: got %0h want 0", bif.byteOut);
    else passes++;
    checks++;
    if (bif.byteValid !== 1'b0) $display("FAIL reset_byteValid: got %0b want 0", bif.byteValid);
    else passes++;
    checks++;
    if (bif.byteLast !== 1'b0) $display("FAIL reset_byteLast: got %0b want 0", bif.byteLast);
    else passes++;
    checks++;
    if (bytesLeft !== 11'd0) $display("FAIL reset_bytesLeft: got %0d want 0", bytesLeft);
    else passes++;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_busy_done: got %0b%0b want 00", busy, done);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    logic [7:0] eb [8] = '{8'h11, 8'h22, 8'h33, 8'h44,
                           8'h55, 8'h66, 8'h77, 8'h88};
    int ec [8] = '{3, 4, 5, 6, 8, 9, 10, 11};
    push(32'h44332211);
    push(32'h88776655);
    run(8, 16, 0, 4'hF, -1, 0, -1);
    checks++;
    if (acc_b.size() != 8) $display("FAIL normal_count: got %0d want 8", acc_b.size());
    else passes++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (acc_b[i] !== eb[i] || acc_c[i] != ec[i])
        $display("FAIL normal_byte%0d: got %0h@%0d want %0h@%0d",
                 i, acc_b[i], acc_c[i], eb[i], ec[i]);
      else passes++;
      checks++;
      if (acc_l[i] !== (i == 7) || acc_left[i] !== 11'(8 - i))
        $display("FAIL normal_last_left%0d: got %0b/%0d want %0b/%0d",
                 i, acc_l[i], acc_left[i], (i == 7), 8 - i);
      else passes++;
    end
    checks++;
    if (rd_c.size() != 2 || rd_c[0] != 1 || rd_c[1] != 6)
      $display("FAIL normal_reads: got n=%0d first=%0d second=%0d want 2/1/6",
               rd_c.size(), rd_c[0], rd_c[1]);
    else passes++;
    checks++;
    if (done_c.size() != 1 || done_c[0] != 12)
      $display("FAIL normal_done: got n=%0d at %0d want 1 at 12",
               done_c.size(), done_c[0]);
    else passes++;
    checks++;
    if (fwr - frd != 0) $display("FAIL normal_fifo_left: got %0d want 0", fwr - frd);
    else passes++;
  endtask

  task automatic test_partial();
    logic [7:0] eb [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    push(32'h44332211);
    push(32'h88776655);
    run(5, 12, 0, 4'hF, -1, 0, -1);
    checks++;
    if (acc_b.size() != 5) $display("FAIL partial_count: got %0d want 5", acc_b.size());
    else passes++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (acc_b[i] !== eb[i] || acc_l[i] !== (i == 4))
        $display("FAIL partial_byte%0d: got %0h last=%0b want %0h last=%0b",
                 i, acc_b[i], acc_l[i], eb[i], (i == 4));
      else passes++;
    end
    checks++;
    if (rd_c.size() != 2) $display("FAIL partial_reads: got %0d want 2", rd_c.size());
    else passes++;
    checks++;
    if (done_c.size() != 1 || done_c[0] != 9)
      $display("FAIL partial_done: got n=%0d at %0d want 1 at 9",
               done_c.size(), done_c[0]);
    else passes++;
    checks++;
    if (fwr - frd != 0) $display("FAIL partial_fifo_left: got %0d want 0", fwr - frd);
    else passes++;
  endtask

  task automatic test_zero_length();
    push(32'hDEADBEEF);
    run(0, 6, 0, 4'hF, -1, 0, -1);
    checks++;
    if (done_c.size() != 1 || done_c[0] != 1)
      $display("FAIL zlp_done: got n=%0d at %0d want 1 at 1",
               done_c.size(), done_c[0]);
    else passes++;
    checks++;
    if (busy_n != 0) $display("FAIL zlp_busy: got %0d busy cycles want 0", busy_n);
    else passes++;
    checks++;
    if (rd_c.size() != 0 || valid_n != 0)
      $display("FAIL zlp_activity: got reads=%0d valids=%0d want 0/0",
               rd_c.size(), valid_n);
    else passes++;
    checks++;
    if (fwr - frd != 1) $display("FAIL zlp_fifo_left: got %0d want 1", fwr - frd);
    else passes++;
    fwr = frd;
  endtask

  task automatic test_stall_backpressure();
    logic [7:0] eb [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    int ec [4] = '{8, 11, 12, 15};
    push(32'hDDCCBBAA);
    run(4, 20, 6, 4'b1001, -1, 0, -1);
    checks++;
    if (rd_empty_n != 0) $display("FAIL stall_rd_empty: got %0d strobes want 0", rd_empty_n);
    else passes++;
    checks++;
    if (rd_c.size() != 1 || rd_c[0] != 6)
      $display("FAIL stall_read: got n=%0d at %0d want 1 at 6",
               rd_c.size(), rd_c[0]);
    else passes++;
    checks++;
    if (acc_b.size() != 4) $display("FAIL stall_count: got %0d want 4", acc_b.size());
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (acc_b[i] !== eb[i] || acc_c[i] != ec[i] ||
          acc_left[i] !== 11'(4 - i))
        $display("FAIL stall_byte%0d: got %0h@%0d left=%0d want %0h@%0d left=%0d",
                 i, acc_b[i], acc_c[i], acc_left[i], eb[i], ec[i], 4 - i);
      else passes++;
    end
    checks++;
    if (hold_bad != 0) $display("FAIL stall_hold: got %0d unstable cycles want 0", hold_bad);
    else passes++;
    checks++;
    if (done_c.size() != 1 || done_c[0] != 16)
      $display("FAIL stall_done: got n=%0d at %0d want 1 at 16",
               done_c.size(), done_c[0]);
    else passes++;
  endtask

  task automatic test_abort();
    logic [7:0] eb [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    push(32'h04030201);
    push(32'h08070605);
    push(32'h0C0B0A09);
    run(12, 10, 0, 4'hF, -1, 0, 4);
    checks++;
    if (s_out[4] !== 8'h02 || !s_val[4])
      $display("FAIL abort_presented: got %0h v=%0b want 02 v=1", s_out[4], s_val[4]);
    else passes++;
    checks++;
    if (s_val[5] || s_out[5] !== 8'h00 || s_last[5] || s_rd[5])
      $display("FAIL abort_stream: got v=%0b out=%0h last=%0b rd=%0b want 0/00/0/0",
               s_val[5], s_out[5], s_last[5], s_rd[5]);
    else passes++;
    checks++;
    if (s_left[5] !== 11'd0 || s_busy[5] || s_done[5])
      $display("FAIL abort_status: got left=%0d busy=%0b done=%0b want 0/0/0",
               s_left[5], s_busy[5], s_done[5]);
    else passes++;
    checks++;
    if (done_c.size() != 0) $display("FAIL abort_no_done: got %0d pulses want 0", done_c.size());
    else passes++;
    checks++;
    if (fwr - frd != 2) $display("FAIL abort_fifo_left: got %0d want 2", fwr - frd);
    else passes++;
    fwr = frd;
    push(32'h44332211);
    run(4, 10, 0, 4'hF, -1, 0, -1);
    checks++;
    if (acc_b.size() != 4) $display("FAIL abort_next_count: got %0d want 4", acc_b.size());
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (acc_b[i] !== eb[i] || acc_c[i] != 3 + i)
        $display("FAIL abort_next_byte%0d: got %0h@%0d want %0h@%0d",
                 i, acc_b[i], acc_c[i], eb[i], 3 + i);
      else passes++;
    end
    checks++;
    if (done_c.size() != 1 || done_c[0] != 7)
      $display("FAIL abort_next_done: got n=%0d at %0d want 1 at 7",
               done_c.size(), done_c[0]);
    else passes++;
  endtask

  task automatic test_start_while_busy();
    logic [7:0] eb [8] = '{8'h11, 8'h22, 8'h33, 8'h44,
                           8'h55, 8'h66, 8'h77, 8'h88};
    push(32'h44332211);
    push(32'h88776655);
    run(8, 16, 0, 4'hF, 5, 9, -1);
    checks++;
    if (acc_b.size() != 8) $display("FAIL busy_count: got %0d want 8", acc_b.size());
    else passes++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (acc_b[i] !== eb[i])
        $display("FAIL busy_byte%0d: got %0h want %0h", i, acc_b[i], eb[i]);
      else passes++;
    end
    checks++;
    if (s_left[6] !== 11'd5) $display("FAIL busy_left: got %0d want 5", s_left[6]);
    else passes++;
    checks++;
    if (done_c.size() != 1 || done_c[0] != 12)
      $display("FAIL busy_done: got n=%0d at %0d want 1 at 12",
               done_c.size(), done_c[0]);
    else passes++;
    checks++;
    if (s_left[13] !== 11'd0 || s_busy[13])
      $display("FAIL busy_idle_after: got left=%0d busy=%0b want 0/0",
               s_left[13], s_busy[13]);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_partial();
    test_zero_length();
    test_stall_backpressure();
    test_abort();
    test_start_while_busy();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
